// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_pkg
// Description : Shared constants, FSM state encoding and the round-robin
//               selection helper for the 8-way arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter_pkg;

    // Number of requesters and the width of a requester index
    localparam int c_N_REQ            = 8;
    localparam int c_IDX_W            = 3;

    // Hold counter width and the default grant-hold limit
    localparam int c_CNT_W            = 4;
    localparam int c_HOLD_MAX_DEFAULT = 15;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE    = 2'b00;
    localparam state_t c_ST_GRANT   = 2'b01;
    localparam state_t c_ST_RELEASE = 2'b10;

    // Return the first requester with its bit set, scanning upward from ptr
    // and wrapping past the top index. The 3-bit add wraps modulo 8 for free.
    // Returns 0 when nothing is requested; callers qualify with |req.
    function automatic logic [c_IDX_W-1:0] rr_pick(
        input logic [c_N_REQ-1:0] req_vec,
        input logic [c_IDX_W-1:0] ptr
    );
        logic [c_IDX_W-1:0] idx;
        logic [c_IDX_W-1:0] cand;
        logic               found;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < c_N_REQ; k++) begin
            cand = ptr + c_IDX_W'(k);
            if (!found && req_vec[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m8X3_encoder.sv
`default_nettype none
// ============================================================================
// Module      : m8X3_encoder
// Description : 8-to-3 binary encoder for a one-hot (or all-zero) input.
//               {x,y,z} is the index of the set bit; all-zero input gives 0.
// Revision    : 1.0 - initial release
// ============================================================================
module m8X3_encoder (
    input  logic [7:0] d,
    output logic       x,
    output logic       y,
    output logic       z
);

    // Each output bit is the OR of the input positions whose index has it set
    assign x = d[7] | d[6] | d[5] | d[4];
    assign y = d[7] | d[6] | d[3] | d[2];
    assign z = d[7] | d[5] | d[3] | d[1];

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_8
// Description : 8-requester round-robin arbiter with registered one-hot
//               grant, bounded grant tenure (HOLD_MAX) and a mandatory
//               one-cycle release gap between grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_8
    import rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = c_HOLD_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [c_N_REQ-1:0] req,
    output logic [c_N_REQ-1:0] gnt,
    output logic [c_IDX_W-1:0] gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    // Hold limit in counter width
    localparam logic [c_CNT_W-1:0] c_HOLD_LIM = c_CNT_W'(HOLD_MAX);

    // Registered state and the matching next values
    state_t               state_q,    state_d;
    logic [c_IDX_W-1:0]   ptr_q,      ptr_d;
    logic [c_IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [c_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [c_N_REQ-1:0]   gnt_q,      gnt_d;
    logic                 timeout_q,  timeout_d;

    // Combinational helpers
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic                 w_any_req;
    logic                 w_own_req;
    logic                 w_hold_done;
    logic                 w_enc_x;
    logic                 w_enc_y;
    logic                 w_enc_z;

    assign w_any_req   = |req;
    assign w_pick_idx  = rr_pick(req, ptr_q);
    // last_idx_q tracks the current owner for the whole GRANT tenure
    assign w_own_req   = req[last_idx_q];
    assign w_hold_done = (hold_cnt_q == c_HOLD_LIM);

    // State register and all datapath flops, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= c_ST_IDLE;
            ptr_q      <= '0;
            last_idx_q <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_idx_q <= last_idx_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: arbitrate, hold until drop or limit, one release cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    state_d = c_ST_GRANT;
                end
            end
            c_ST_GRANT: begin
                if (!w_own_req || w_hold_done) begin
                    state_d = c_ST_RELEASE;
                end
            end
            c_ST_RELEASE: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // Output/datapath logic: next grant vector, hold count, pointer, timeout
    always_comb begin
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        last_idx_d = last_idx_q;
        timeout_d  = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                gnt_d      = '0;
                hold_cnt_d = '0;
                if (w_any_req) begin
                    gnt_d      = c_N_REQ'(1) << w_pick_idx;
                    hold_cnt_d = c_CNT_W'(1);
                    last_idx_d = w_pick_idx;
                end
            end
            c_ST_GRANT: begin
                if (!w_own_req) begin
                    // Owner finished: voluntary release, no timeout
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                end else if (w_hold_done) begin
                    // Owner still requesting at the limit: revoke and flag it
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + c_CNT_W'(1);
                end
            end
            c_ST_RELEASE: begin
                // Last owner becomes lowest priority for the next search
                gnt_d = '0;
                ptr_d = last_idx_q + c_IDX_W'(1);
            end
            default: begin
                gnt_d      = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Binary index of the registered grant
    m8X3_encoder u_gnt_enc (
        .d (gnt_q),
        .x (w_enc_x),
        .y (w_enc_y),
        .z (w_enc_z)
    );

    assign gnt       = gnt_q;
    assign gnt_idx   = {w_enc_x, w_enc_y, w_enc_z};
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_8
// Description : Self-checking bench for rr_arbiter_8 (HOLD_MAX 15 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;

    logic [7:0] gnt_a,  gnt_b;
    logic [2:0] idx_a,  idx_b;
    logic       val_a,  val_b;
    logic       to_a,   to_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_arbiter_8 dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt_a),
        .gnt_idx   (idx_a),
        .gnt_valid (val_a),
        .timeout   (to_a)
    );

    rr_arbiter_8 #(.HOLD_MAX(2)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt_b),
        .gnt_idx   (idx_b),
        .gnt_valid (val_b),
        .timeout   (to_b)
    );

    // ------------------------------------------------------------------
    // Reference model, one per DUT: owner (-1 = none), tenure age,
    // pending release cycle, rotation pointer.
    // ------------------------------------------------------------------
    int m_hold  [2] = '{15, 2};
    int m_owner [2] = '{-1, -1};
    int m_age   [2] = '{0, 0};
    int m_ptr   [2] = '{0, 0};
    int m_last  [2] = '{0, 0};
    bit m_rel   [2] = '{1'b0, 1'b0};
    bit m_to    [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_owner[i] = -1;
                m_age[i]   = 0;
                m_ptr[i]   = 0;
                m_last[i]  = 0;
                m_rel[i]   = 1'b0;
                m_to[i]    = 1'b0;
            end else if (m_rel[i]) begin
                m_rel[i] = 1'b0;
                m_to[i]  = 1'b0;
                m_ptr[i] = (m_last[i] + 1) % 8;
            end else if (m_owner[i] >= 0) begin
                if (!req[m_owner[i]] || m_age[i] == m_hold[i]) begin
                    m_to[i]    = req[m_owner[i]];
                    m_rel[i]   = 1'b1;
                    m_last[i]  = m_owner[i];
                    m_owner[i] = -1;
                end else begin
                    m_age[i] = m_age[i] + 1;
                end
            end else if (req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_owner[i] < 0 && req[(m_ptr[i] + k) % 8]) begin
                        m_owner[i] = (m_ptr[i] + k) % 8;
                        m_age[i]   = 1;
                    end
                end
            end
        end
    end

    function automatic logic [12:0] m_exp(input int i);
        logic [7:0] g;
        logic [2:0] x;
        g = 8'h00;
        x = 3'd0;
        if (m_owner[i] >= 0) begin
            g[m_owner[i]] = 1'b1;
            x = 3'(m_owner[i]);
        end
        return {g, x, |g, m_rel[i] & m_to[i]};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [12:0] obs;
        reset_n = 1'b0;
        req     = 8'hFF;
        repeat (3) @(negedge clk);
        obs = {gnt_a, idx_a, val_a, to_a};
        n_checks++;
        if (obs !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want %h", obs, 13'd0);
        end
        obs = {gnt_b, idx_b, val_b, to_b};
        n_checks++;
        if (obs !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want %h", obs, 13'd0);
        end
        req     = 8'h00;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({gnt_a, val_a} !== 9'd0) begin
                n_fail++;
                $display("FAIL idle_no_req: got gnt=%h v=%b want 00/0", gnt_a, val_a);
            end
        end
    endtask

    // Single requester 2, held 3 edges; next grant proves ptr=3
    task automatic test_single();
        logic [12:0] e;
        logic [12:0] obs;
        do_reset();
        req = 8'h04;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            case (t)
                1, 2, 3: e = {8'h04, 3'd2, 1'b1, 1'b0};
                6:       e = {8'h08, 3'd3, 1'b1, 1'b0};
                default: e = 13'd0;
            endcase
            obs = {gnt_a, idx_a, val_a, to_a};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL single c%0d: got %h want %h", t, obs, e);
            end
            if (t == 3) req = 8'h00;
            if (t == 4) req = 8'h09;
        end
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    // All requesting, HOLD_MAX=2: 0..7,0 each 2 cycles, timeout, gap
    task automatic test_rotation();
        logic [12:0] e;
        logic [12:0] obs;
        logic [7:0]  eg;
        int          ph;
        int          k;
        do_reset();
        req = 8'hFF;
        for (int t = 0; t < 36; t++) begin
            @(negedge clk);
            ph = t % 4;
            k  = (t / 4) % 8;
            eg = 8'h00;
            if (ph < 2) eg[k] = 1'b1;
            e   = {eg, (ph < 2) ? 3'(k) : 3'd0, ph < 2, ph == 2};
            obs = {gnt_b, idx_b, val_b, to_b};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rotation c%0d: got %h want %h", t, obs, e);
            end
        end
        req = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    // Serve idx 6 (ptr -> 7), then req 0000_0011 gives idx 0 then idx 1
    task automatic test_wrap();
        logic [12:0] e;
        logic [12:0] obs;
        do_reset();
        req = 8'h40;
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            case (t)
                1:       e = {8'h40, 3'd6, 1'b1, 1'b0};
                4:       e = {8'h01, 3'd0, 1'b1, 1'b0};
                7:       e = {8'h02, 3'd1, 1'b1, 1'b0};
                default: e = 13'd0;
            endcase
            obs = {gnt_a, idx_a, val_a, to_a};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL wrap c%0d: got %h want %h", t, obs, e);
            end
            if (t == 1) req = 8'h00;
            if (t == 2) req = 8'h03;
            if (t == 4) req = 8'h02;
        end
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    // HOLD_MAX=15, req 7 held 20 edges: 15 grant cycles, one timeout, regrant
    task automatic test_timeout();
        logic [12:0] e;
        logic [12:0] obs;
        int          n_to;
        do_reset();
        req  = 8'h80;
        n_to = 0;
        for (int t = 1; t <= 21; t++) begin
            @(negedge clk);
            if (t <= 15 || (t >= 18 && t <= 20)) e = {8'h80, 3'd7, 1'b1, 1'b0};
            else if (t == 16)                    e = {8'h00, 3'd0, 1'b0, 1'b1};
            else                                 e = 13'd0;
            obs = {gnt_a, idx_a, val_a, to_a};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL timeout c%0d: got %h want %h", t, obs, e);
            end
            if (to_a) n_to++;
            if (t == 20) req = 8'h00;
        end
        n_checks++;
        if (n_to !== 1) begin
            n_fail++;
            $display("FAIL timeout_pulses: got %0d want 1", n_to);
        end
        repeat (3) @(negedge clk);
    endtask

    // Reset during a grant to idx 5 clears at once; ptr restarts at 0
    task automatic test_reset_mid();
        logic [12:0] obs;
        do_reset();
        req = 8'h08;
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        req = 8'h20;
        repeat (2) @(negedge clk);
        obs = {gnt_a, idx_a, val_a, to_a};
        n_checks++;
        if (obs !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %h want %h", obs, {8'h20, 3'd5, 1'b1, 1'b0});
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        obs = {gnt_a, idx_a, val_a, to_a};
        n_checks++;
        if (obs !== 13'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h want %h", obs, 13'd0);
        end
        req = 8'h21;
        @(negedge clk);
        n_checks++;
        if (gnt_a !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_held: got %h want 00", gnt_a);
        end
        reset_n = 1'b1;
        @(negedge clk);
        obs = {gnt_a, idx_a, val_a, to_a};
        n_checks++;
        if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_post_a: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
        end
        n_checks++;
        if (gnt_b !== 8'h01) begin
            n_fail++;
            $display("FAIL rstmid_post_b: got %h want 01", gnt_b);
        end
        req = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    // req[1] rising while idx 3 owns the grant is ignored
    task automatic test_ignored();
        logic [12:0] e;
        logic [12:0] obs;
        do_reset();
        req = 8'h08;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            case (t)
                1, 2, 3, 4, 5: e = {8'h08, 3'd3, 1'b1, 1'b0};
                8:             e = {8'h02, 3'd1, 1'b1, 1'b0};
                default:       e = 13'd0;
            endcase
            obs = {gnt_a, idx_a, val_a, to_a};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL ignored c%0d: got %h want %h", t, obs, e);
            end
            if (t == 2) req = 8'h0A;
            if (t == 5) req = 8'h02;
        end
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    // Random request traffic with occasional resets, both DUTs vs model
    task automatic test_random();
        logic [12:0] obs;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            obs = {gnt_a, idx_a, val_a, to_a};
            n_checks++;
            if (obs !== m_exp(0)) begin
                n_fail++;
                $display("FAIL random_a c%0d: got %h want %h", c, obs, m_exp(0));
            end
            obs = {gnt_b, idx_b, val_b, to_b};
            n_checks++;
            if (obs !== m_exp(1)) begin
                n_fail++;
                $display("FAIL random_b c%0d: got %h want %h", c, obs, m_exp(1));
            end
            n_checks++;
            if (!$onehot0(gnt_a) || val_a !== (|gnt_a) || !$onehot0(gnt_b) || val_b !== (|gnt_b)) begin
                n_fail++;
                $display("FAIL random_onehot c%0d: got a=%h/%b b=%h/%b want onehot0 with valid=|gnt",
                         c, gnt_a, val_a, gnt_b, val_b);
            end
            for (int b = 0; b < 8; b++) begin
                if (req[b]) begin
                    if ($urandom_range(0, 7) == 0) req[b] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) req[b] = 1'b1;
                end
            end
            reset_n = ($urandom_range(0, 399) != 0);
        end
        reset_n = 1'b1;
        req     = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 8'h00;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15: maximum consecutive cycles one grant may be held (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req  input  8  request lines, one per requester; a requester holds its bit high until finished.
REQ-005 SHALL have port gnt  output  8  registered one-hot grant; all zeros when no grant.
REQ-006 SHALL have port gnt_idx  output  3  binary index of the asserted gnt bit; 3'd0 when gnt_valid=0.
REQ-007 SHALL have port gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-008 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by the HOLD_MAX limit.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-010 SHALL, in IDLE with req!=0, select the first set bit searching upward from ptr with wrap (ptr, ptr+1, ..., 7, 0, ...), register its one-hot grant, and enter GRANT on the same edge.
REQ-011 SHALL keep gnt=0 and stay in IDLE while req==0.
REQ-012 SHALL give latency of one edge: req sampled high at edge N gives gnt visible after edge N.
REQ-013 SHALL hold gnt unchanged in GRANT while req[gnt_idx]=1 and hold_cnt<HOLD_MAX; changes on other req bits are ignored.
REQ-014 SHALL load hold_cnt to 1 on entering GRANT and increment it each further GRANT cycle (4-bit, no wrap needed within range).
REQ-015 SHALL, when req[gnt_idx] is sampled low in GRANT, clear gnt and enter RELEASE.
REQ-016 SHALL, when hold_cnt==HOLD_MAX and req[gnt_idx] is still high, clear gnt, enter RELEASE, and assert timeout for that RELEASE cycle only.
REQ-017 SHALL, in RELEASE, set ptr=(gnt_idx_last+1) mod 8 (7 wraps to 0) and return to IDLE; gnt=0 for this cycle.
REQ-018 SHALL make a timed-out requester that keeps req high lowest priority in the next arbitration, with no special exclusion.
REQ-019 SHALL give a grant lasting at most HOLD_MAX cycles, followed by exactly one idle cycle (RELEASE), with the next grant at the earliest one cycle later (from IDLE).
REQ-020 SHALL guarantee that gnt is never multi-hot and gnt_valid==|gnt in every cycle.

Reset
REQ-021 SHALL, on reset_n low and independent of clk, force state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
REQ-022 SHALL abort any grant in progress on reset mid-grant; after reset_n rises, the first arbitration uses ptr=0.

Structure
REQ-023 SHALL place the state encoding (IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10), the requester count 8, and the HOLD_MAX default in a shared package rr_arbiter_pkg.
REQ-024 SHALL derive gnt_idx from gnt with one instance of the existing m8X3_encoder sub-module, mapping its {x,y,z} outputs to gnt_idx[2:0].

Verification
REQ-025 SHALL cover single request: reset, req=8'b0000_0100 held 3 cycles then dropped -> gnt=8'b0000_0100, gnt_idx=2 for 3 cycles, one RELEASE cycle, ptr=3.
REQ-026 SHALL cover rotation: req=8'hFF held continuously, HOLD_MAX=2 -> grants in order idx 0,1,2,...,7,0, each 2 cycles with timeout pulse and a 2-cycle gap (RELEASE+IDLE).
REQ-027 SHALL cover wrap: ptr=7 (after serving idx 6), req=8'b0000_0011 -> grant idx 0, then idx 1.
REQ-028 SHALL cover timeout: HOLD_MAX=15, req=8'b1000_0000 held 20 cycles -> gnt high exactly 15 cycles, timeout high 1 cycle, then re-grant idx 7.
REQ-029 SHALL cover reset mid-grant: reset_n low during a grant to idx 5 -> gnt=0 immediately; after release, req=8'b0010_0001 -> grant idx 0.
REQ-030 SHALL cover ignored change: while idx 3 is granted, req[1] rises -> gnt stays 8'b0000_1000 until req[3] drops.
